// File: rtl/narma_pkg.sv
// Shared constants and types for the NARMA-10 generator.
// Values are unsigned Q6.10: the real value is code/1024.
package narma_pkg;

   localparam int Q_FRAC      = 10;
   localparam int C_A         = 307;   // 0.3
   localparam int C_B         = 51;    // 0.05
   localparam int C_C         = 1536;  // 1.5
   localparam int C_D         = 102;   // 0.1
   localparam int U_MASK_BITS = 9;

   // Right-shifting Fibonacci LFSR: these bits form x^16+x^14+x^13+x^11+1
   localparam int LFSR_TAP0 = 0;
   localparam int LFSR_TAP1 = 2;
   localparam int LFSR_TAP2 = 3;
   localparam int LFSR_TAP3 = 5;

   typedef logic [15:0] q6_10_t;

endpackage

// File: rtl/narma_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the NARMA input sequence.
// A zero seed is replaced by 1 so that the register can never lock up.
module narma_lfsr
   import narma_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q, lfsr_d;
   logic        fb;

   always_comb begin
      fb     = lfsr_q[LFSR_TAP0] ^ lfsr_q[LFSR_TAP1] ^ lfsr_q[LFSR_TAP2] ^ lfsr_q[LFSR_TAP3];
      lfsr_d = {fb, lfsr_q[15:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= SEED_EFF;
      else      lfsr_q <= lfsr_d;
   end

   assign state = lfsr_q;

endmodule

// File: rtl/narma_system.sv
// Free-running NARMA-10 target generator: one Q6.10 sample per clock,
// driven by an internal LFSR input sequence.
module narma_system
   import narma_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          HIST_LEN  = 10
) (
   input  logic   clk,
   input  logic   rst,
   output q6_10_t narma_output,
   output q6_10_t narma_input,
   output logic   out_valid
);

   localparam q6_10_t U_MASK = 16'((1 << U_MASK_BITS) - 1);

   logic [15:0] lfsr_state;
   q6_10_t      u_t;

   q6_10_t [HIST_LEN-1:0] y_h_q, y_h_d;
   q6_10_t [HIST_LEN-2:0] u_h_q, u_h_d;
   logic   [3:0]          warm_q, warm_d;

   logic [19:0] sum_s;
   logic [25:0] p;
   logic [7:0]  q;
   logic [27:0] a, b, c, y_sum;
   q6_10_t      y_next;

   narma_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr_state)
   );

   assign u_t = lfsr_state & U_MASK;

   // Every product is sized so that nothing is lost before the floor shift.
   always_comb begin
      sum_s = '0;
      for (int k = 0; k < HIST_LEN; k++) sum_s = sum_s + 20'(y_h_q[k]);
      a      = 28'((26'(C_A) * 26'(y_h_q[0])) >> Q_FRAC);
      p      = 26'((36'(y_h_q[0]) * 36'(sum_s)) >> Q_FRAC);
      b      = 28'((32'(C_B) * 32'(p)) >> Q_FRAC);
      q      = 8'((32'(u_t) * 32'(u_h_q[HIST_LEN-2])) >> Q_FRAC);
      c      = 28'((19'(C_C) * 19'(q)) >> Q_FRAC);
      y_sum  = a + b + c + 28'(C_D);
      y_next = (y_sum > 28'h000FFFF) ? 16'hFFFF : y_sum[15:0];
   end

   always_comb begin
      y_h_d  = {y_h_q[HIST_LEN-2:0], y_next};
      u_h_d  = {u_h_q[HIST_LEN-3:0], u_t};
      warm_d = (warm_q == 4'(HIST_LEN)) ? warm_q : warm_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_h_q  <= '0;
         u_h_q  <= '0;
         warm_q <= '0;
      end else begin
         y_h_q  <= y_h_d;
         u_h_q  <= u_h_d;
         warm_q <= warm_d;
      end
   end

   assign narma_output = y_h_q[0];
   assign narma_input  = u_t;
   assign out_valid    = (warm_q == 4'(HIST_LEN));

endmodule

// File: tb/tb_narma_system.sv
// Self-checking bench for narma_system against a queue-based NARMA-10 model.
module tb_narma_system;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rst0 = 1'b0;
   logic [15:0] narma_output, narma_input;
   logic        out_valid;
   logic [15:0] z_output, z_input;
   logic        z_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   longint      my[10];
   longint      mu[9];
   logic [15:0] mlfsr;
   logic [15:0] zlfsr;

   always #5 clk = ~clk;

   narma_system dut (
      .clk          (clk),
      .rst          (rst),
      .narma_output (narma_output),
      .narma_input  (narma_input),
      .out_valid    (out_valid)
   );

   narma_system #(.LFSR_SEED(16'h0000)) dut0 (
      .clk          (clk),
      .rst          (rst0),
      .narma_output (z_output),
      .narma_input  (z_input),
      .out_valid    (z_valid)
   );

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic longint narma_next(input longint yh[10], input longint uh[9], input longint u);
      longint a, s, p, b, qq, c, y;
      s = 0;
      foreach (yh[k]) s += yh[k];
      a  = (307 * yh[0]) / 1024;
      p  = (yh[0] * s) / 1024;
      b  = (51 * p) / 1024;
      qq = (u * uh[8]) / 1024;
      c  = (1536 * qq) / 1024;
      y  = a + b + c + 102;
      return (y > 65535) ? 65535 : y;
   endfunction

   task automatic model_reset();
      foreach (my[k]) my[k] = 0;
      foreach (mu[k]) mu[k] = 0;
      mlfsr = 16'hACE1;
   endtask

   task automatic model_step();
      longint u, y;
      u = longint'(mlfsr % 512);
      y = narma_next(my, mu, u);
      for (int k = 9; k > 0; k--) my[k] = my[k-1];
      my[0] = y;
      for (int k = 8; k > 0; k--) mu[k] = mu[k-1];
      mu[0] = u;
      mlfsr = lfsr_adv(mlfsr);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (narma_output !== 16'h0000) begin
         n_fail++; $display("FAIL reset_output got=%h exp=0000", narma_output);
      end
      n_checks++;
      if (narma_input !== 16'h00E1) begin
         n_fail++; $display("FAIL reset_input got=%h exp=00e1", narma_input);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
   endtask

   // Releases reset and checks the LFSR-independent warm-up samples and out_valid timing.
   task automatic test_warmup();
      longint first[3] = '{102, 132, 142};
      @(negedge clk);
      rst = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         model_step();
         if (e <= 3) begin
            n_checks++;
            if (narma_output !== 16'(first[e-1])) begin
               n_fail++; $display("FAIL warmup_const edge=%0d got=%0d exp=%0d", e, narma_output, first[e-1]);
            end
         end
         n_checks++;
         if (narma_output !== 16'(my[0])) begin
            n_fail++; $display("FAIL warmup_model edge=%0d got=%0d exp=%0d", e, narma_output, my[0]);
         end
         n_checks++;
         if (out_valid !== (e >= 10)) begin
            n_fail++; $display("FAIL warmup_valid edge=%0d got=%b exp=%b", e, out_valid, (e >= 10));
         end
         n_checks++;
         if (narma_input !== {7'b0, mlfsr[8:0]}) begin
            n_fail++; $display("FAIL warmup_input edge=%0d got=%h exp=%h", e, narma_input, mlfsr[8:0]);
         end
      end
   endtask

   task automatic test_random_run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         model_step();
         n_checks++;
         if (narma_output !== 16'(my[0])) begin
            n_fail++; $display("FAIL run_output cyc=%0d got=%0d exp=%0d", i, narma_output, my[0]);
         end
         n_checks++;
         if (narma_input > 16'd511 || narma_input !== {7'b0, mlfsr[8:0]}) begin
            n_fail++; $display("FAIL run_input cyc=%0d got=%0d exp=%0d", i, narma_input, mlfsr[8:0]);
         end
         n_checks++;
         if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL run_valid cyc=%0d got=%b exp=1", i, out_valid);
         end
      end
   endtask

   // Asserts reset between edges and expects immediate clearing, then a clean restart.
   task automatic test_mid_reset();
      test_random_run($urandom_range(1, 40));
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (narma_output !== 16'h0000 || out_valid !== 1'b0 || narma_input !== 16'h00E1) begin
         n_fail++;
         $display("FAIL midreset_clear got=%h/%b/%h exp=0000/0/00e1", narma_output, out_valid, narma_input);
      end
      repeat ($urandom_range(1, 4)) @(posedge clk);
      test_warmup();
      test_random_run(50);
   endtask

   task automatic test_saturation();
      @(negedge clk);
      rst = 1'b0;
      force dut.y_h_q = {10{16'hF000}};
      #1;
      foreach (my[k]) my[k] = 64'hF000;
      foreach (mu[k]) mu[k] = 0;
      n_checks++;
      if (dut.y_next !== 16'(narma_next(my, mu, 225))) begin
         n_fail++; $display("FAIL sat_model got=%h exp=%h", dut.y_next, narma_next(my, mu, 225));
      end
      n_checks++;
      if (dut.y_next !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_value got=%h exp=ffff", dut.y_next);
      end
      release dut.y_h_q;
      @(posedge clk);
      #1;
      n_checks++;
      if (narma_output !== 16'h0000) begin
         n_fail++; $display("FAIL sat_cleanup got=%h exp=0000", narma_output);
      end
   endtask

   task automatic test_seed_zero();
      int changes = 0;
      logic [15:0] prev;
      zlfsr = 16'h0001;
      n_checks++;
      if (z_input !== 16'h0001) begin
         n_fail++; $display("FAIL seed0_reset got=%h exp=0001", z_input);
      end
      prev = z_input;
      @(negedge clk);
      rst0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         zlfsr = lfsr_adv(zlfsr);
         n_checks++;
         if (z_input !== {7'b0, zlfsr[8:0]}) begin
            n_fail++; $display("FAIL seed0_seq cyc=%0d got=%h exp=%h", i, z_input, zlfsr[8:0]);
         end
         if (z_input !== prev) changes++;
         prev = z_input;
      end
      n_checks++;
      if (changes < 5) begin
         n_fail++; $display("FAIL seed0_varies got=%0d changes exp>=5", changes);
      end
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_random_run(2000);
      test_mid_reset();
      test_saturation();
      test_seed_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/narma_system.md
Name: narma_system

Overview:
- Self-contained NARMA-10 benchmark generator.
- Produces one new target sample y(t) per clock as unsigned Q6.10 fixed point (real value = code/1024).
- The input sequence u(t) comes from an internal LFSR.
- Downstream blocks (bitstream converter, LIF reservoir) consume narma_output as the reservoir drive/target signal.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero LFSR reset state. A value of 0 is replaced by 16'h0001.
- HIST_LEN, 10, NARMA order (y history depth and u delay). Fixed at 10; other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- narma_output  output  16  current y(t), unsigned Q6.10.
- narma_input  output  16  current u(t), unsigned Q6.10, range 0..511 (0 to ~0.499).
- out_valid  output  1  high once the history is fully populated.

Behaviour:
- Reset (rst=0, asynchronous):
  - y history y_h[0..9] = 0; narma_output = y_h[0] = 0.
  - u history u_h[0..8] = 0.
  - LFSR = LFSR_SEED.
  - Warm-up counter = 0; out_valid = 0.
- Input generation:
  - LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1; shifts once per clock when rst=1.
  - u(t) = {7'b0, lfsr[8:0]}, combinational from the current LFSR state; narma_input = u(t).
- Histories:
  - y_h[k] = y(t-k) for k=0..9.
  - u_h[k] = u(t-1-k) for k=0..8, so u(t-9) = u_h[8].
- Next-sample arithmetic (combinational, exact widths, floor truncation at every >>10):
  - a = (307 * y_h[0]) >> 10   (0.3)
  - s = sum of y_h[0..9], 20-bit unsigned
  - p = (y_h[0] * s) >> 10, 26-bit; b = (51 * p) >> 10   (0.05)
  - q = (u(t) * u_h[8]) >> 10; c = (1536 * q) >> 10   (1.5)
  - y_next = a + b + c + 102   (0.1), summed at ≥28 bits
  - y_next saturates to 16'hFFFF when the sum > 65535; no wrap-around.
- Each rising clk with rst=1:
  - y_h shifts (y_h[k] <= y_h[k-1]) and y_h[0] <= y_next.
  - u_h shifts and u_h[0] <= u(t).
  - LFSR advances.
  - Warm-up counter increments, saturating at 10.
- Latency: one clock from history state to narma_output update.
- out_valid = 1 when the counter reaches 10, i.e. after the 10th update following reset release. It stays 1 until reset.
- Reset asserted mid-operation clears all state immediately. Release restarts the exact deterministic sequence.
- No enable or handshake: free-running one sample per clock.

Decomposition:
- Package narma_pkg holds:
  - Q_FRAC=10
  - coefficient constants C_A=307, C_B=51, C_C=1536, C_D=102
  - U_MASK_BITS=9
  - LFSR tap positions
  - typedef q6_10_t (logic [15:0])
- One sub-module, narma_lfsr (16-bit LFSR, async active-low reset to seed, outputs state).
- History shift registers and arithmetic stay in narma_system.

Test Plan:
- Hold rst=0 → narma_output=0, narma_input=LFSR_SEED[8:0] (0x0E1 for 16'hACE1), out_valid=0. Assert rst=0 mid-run → outputs clear asynchronously before the next edge.
- Release reset, first 3 rising edges → narma_output = 102, 132, 142 (0x0066, 0x0084, 0x008E). The u(t-9) term is 0 during warm-up, so these values are LFSR-independent.
- Count edges after release → out_valid rises exactly at the 10th edge and never falls while rst=1.
- After warm-up, compare every sample for 2000 cycles against a bit-accurate reference model of the formulas above → exact match. Check narma_input is always ≤ 511.
- Force y_h to all 16'hF000 (backdoor or preload) → next narma_output = 16'hFFFF (saturation, no wrap).
- Parameter LFSR_SEED=0 → LFSR behaves as seed 1, never locks at zero. narma_input is non-constant over 20 cycles.
